// File: rtl/sync_up_counter_mod.sv
// sync_up_counter_mod: modulo-MODULUS up counter with a clock-enable
// prescaler, synchronous clear/load, a combinational carry for cascading,
// a saturating wrap tally and a sticky out-of-range-load flag.
`timescale 1ns/1ps
module sync_up_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Count,
    output logic             tc,
    output logic [7:0]       wraps,
    output logic             err
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST   = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2^WIDTH is representable for the range check.
    localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_presc;
    logic [7:0]       r_wraps;
    logic             r_err;

    logic w_tick;
    logic w_at_last;
    logic w_load_ok;

    // Tally increment that sticks at 255 instead of rolling over.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Next count on a tick: wrap at MODULUS-1, never at 2^WIDTH.
    function automatic logic [WIDTH-1:0] mod_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_LAST) ? '0 : v + WIDTH'(1);
    endfunction

    assign w_tick    = en && (r_presc == PRESC_LAST);
    assign w_at_last = (r_count == CNT_LAST);
    assign w_load_ok = ({1'b0, load_val} < MOD_EXT);

    // Carry is gated by every higher-priority action so it only marks a real wrap.
    assign tc = w_tick && w_at_last && !clr && !load && !rst;

    // Count and prescaler: clr > load > tick > prescale advance; en low holds.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_presc <= '0;
        end else if (clr) begin
            r_count <= '0;
            r_presc <= '0;
        end else if (load) begin
            r_presc <= '0;
            if (w_load_ok) begin
                r_count <= load_val;
            end
        end else if (w_tick) begin
            r_presc <= '0;
            r_count <= mod_inc(r_count);
        end else if (en) begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Wrap tally: cleared by clr, bumped only on a tick that actually wraps.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_wraps <= '0;
        end else if (clr) begin
            r_wraps <= '0;
        end else if (!load && w_tick && w_at_last) begin
            r_wraps <= sat_inc8(r_wraps);
        end
    end

    // Sticky error: set by an out-of-range load not overridden by clr; only rst clears it.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!clr && load && !w_load_ok) begin
            r_err <= 1'b1;
        end
    end

    assign Count = r_count;
    assign wraps = r_wraps;
    assign err   = r_err;

endmodule

// File: tb/tb_sync_up_counter_mod.sv
// Bench for sync_up_counter_mod: three instances with different parameter
// sets, a reference model per instance and a scoreboard queue of expected
// post-edge states.
`timescale 1ns/1ps
module tb_sync_up_counter_mod;

    logic Clk = 1'b0;
    logic rst = 1'b0;
    always #5 Clk = ~Clk;

    logic       en   [3];
    logic       clr  [3];
    logic       load [3];
    logic [3:0] lv   [3];

    logic [3:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic       tco  [3];
    logic [7:0] wr   [3];
    logic       er   [3];

    sync_up_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u0 (
        .Clk(Clk), .rst(rst), .en(en[0]), .clr(clr[0]), .load(load[0]),
        .load_val(lv[0]), .Count(cnt0), .tc(tco[0]), .wraps(wr[0]), .err(er[0]));

    sync_up_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u1 (
        .Clk(Clk), .rst(rst), .en(en[1]), .clr(clr[1]), .load(load[1]),
        .load_val(lv[1]), .Count(cnt1), .tc(tco[1]), .wraps(wr[1]), .err(er[1]));

    sync_up_counter_mod #(.WIDTH(2), .MODULUS(4), .PRESCALE(1)) u2 (
        .Clk(Clk), .rst(rst), .en(en[2]), .clr(clr[2]), .load(load[2]),
        .load_val(lv[2][1:0]), .Count(cnt2), .tc(tco[2]), .wraps(wr[2]), .err(er[2]));

    typedef struct {
        int cnt;
        int presc;
        int wraps;
        bit err;
    } mstate_t;

    typedef struct {
        int      id;
        mstate_t s;
    } exp_t;

    int      MODS [3] = '{10, 10, 4};
    int      PSC  [3] = '{1, 3, 1};
    mstate_t mdl  [3];
    exp_t    sb   [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic mstate_t mdl_next(mstate_t s, int m, int p, bit e, bit c, bit l, int v);
        mstate_t n = s;
        bit tk = e && (s.presc == p - 1);
        if (c) begin
            n.cnt = 0; n.presc = 0; n.wraps = 0;
        end else if (l) begin
            n.presc = 0;
            if (v < m) n.cnt = v;
            else       n.err = 1'b1;
        end else if (tk) begin
            n.presc = 0;
            if (s.cnt == m - 1) begin
                n.cnt = 0;
                if (s.wraps < 255) n.wraps = s.wraps + 1;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end else if (e) begin
            n.presc = s.presc + 1;
        end
        return n;
    endfunction

    function automatic int tc_model(mstate_t s, int m, int p, bit e, bit c, bit l, bit r);
        return (e && (s.presc == p - 1) && (s.cnt == m - 1) && !c && !l && !r) ? 1 : 0;
    endfunction

    task automatic read_outs(input int id, output int c, output int t, output int w, output int e);
        case (id)
            0:       c = int'(cnt0);
            1:       c = int'(cnt1);
            default: c = int'(cnt2);
        endcase
        t = int'(tco[id]);
        w = int'(wr[id]);
        e = int'(er[id]);
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < 3; k++) mdl[k] = '{0, 0, 0, 1'b0};
    endtask

    // One clock of stimulus on instance id; expected state is queued at drive time.
    task automatic cyc(input int id, input bit e, input bit c, input bit l, input logic [3:0] v);
        int oc, ot, ow, oe;
        mstate_t nx;
        exp_t ex;
        @(negedge Clk);
        en[id] = e; clr[id] = c; load[id] = l; lv[id] = v;
        #1;
        read_outs(id, oc, ot, ow, oe);
        chk($sformatf("tc_u%0d", id), ot, tc_model(mdl[id], MODS[id], PSC[id], e, c, l, 1'b0));
        nx = mdl_next(mdl[id], MODS[id], PSC[id], e, c, l, int'(v));
        sb.push_back('{id, nx});
        @(posedge Clk);
        #1;
        ex = sb.pop_front();
        read_outs(ex.id, oc, ot, ow, oe);
        chk($sformatf("cnt_u%0d", ex.id), oc, ex.s.cnt);
        chk($sformatf("wraps_u%0d", ex.id), ow, ex.s.wraps);
        chk($sformatf("err_u%0d", ex.id), oe, int'(ex.s.err));
        mdl[ex.id] = ex.s;
        en[id] = 1'b0; clr[id] = 1'b0; load[id] = 1'b0;
    endtask

    task automatic do_reset();
        int oc, ot, ow, oe;
        @(negedge Clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            read_outs(k, oc, ot, ow, oe);
            chk($sformatf("rst_cnt_u%0d", k), oc, 0);
            chk($sformatf("rst_wraps_u%0d", k), ow, 0);
            chk($sformatf("rst_err_u%0d", k), oe, 0);
        end
        @(posedge Clk);
        #1;
        chk("rst_hold_cnt_u0", int'(cnt0), 0);
        @(negedge Clk);
        rst = 1'b0;
        mdl_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int oc, ot, ow, oe;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; clr[k] = 1'b0; load[k] = 1'b0; lv[k] = 4'd0;
        end
        mdl_reset();
        do_reset();

        // Reset and count: 12 enabled clocks, modulus 10.
        for (int i = 0; i < 12; i++) cyc(0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("count12_cnt", int'(cnt0), 2);
        chk("count12_wraps", int'(wr[0]), 1);

        // Prescale 3: 7 on, 4 off, 2 on.
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1'b1, 1'b0, 1'b0, 4'd0);
            if (i == 5) chk("presc_after6", int'(cnt1), 2);
        end
        for (int i = 0; i < 4; i++) cyc(1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("presc_pause", int'(cnt1), 2);
        for (int i = 0; i < 2; i++) cyc(1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("presc_after9", int'(cnt1), 3);

        // Load boundaries.
        cyc(0, 1'b0, 1'b0, 1'b1, 4'd7);
        chk("load7_cnt", int'(cnt0), 7);
        chk("load7_err", int'(er[0]), 0);
        cyc(0, 1'b0, 1'b0, 1'b1, 4'd12);
        chk("load12_cnt", int'(cnt0), 7);
        chk("load12_err", int'(er[0]), 1);
        cyc(0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("clr_cnt", int'(cnt0), 0);
        chk("clr_err", int'(er[0]), 1);

        // Priority: load beats a wrapping tick; clr beats load.
        cyc(0, 1'b0, 1'b0, 1'b1, 4'd9);
        cyc(0, 1'b1, 1'b0, 1'b1, 4'd4);
        chk("ldtick_cnt", int'(cnt0), 4);
        chk("ldtick_wraps", int'(wr[0]), 0);
        cyc(0, 1'b0, 1'b1, 1'b1, 4'd5);
        chk("clrld_cnt", int'(cnt0), 0);
        cyc(0, 1'b0, 1'b0, 1'b1, 4'd9);
        cyc(0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("ld9_wrap_cnt", int'(cnt0), 0);
        chk("ld9_wrap_wraps", int'(wr[0]), 1);
        do_reset();
        chk("rst_clears_err", int'(er[0]), 0);

        // Full range and saturation on the 2-bit instance.
        for (int i = 0; i < 1100; i++) cyc(2, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("sat_wraps", int'(wr[2]), 255);

        // Async reset between edges with Count=5, presc=1 on the prescaled instance.
        for (int i = 0; i < 16; i++) cyc(1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("pre_async_cnt", int'(cnt1), 5);
        en[1] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        read_outs(1, oc, ot, ow, oe);
        chk("async_cnt", oc, 0);
        chk("async_tc", ot, 0);
        chk("async_wraps", ow, 0);
        chk("async_err", oe, 0);
        @(negedge Clk);
        rst = 1'b0;
        en[1] = 1'b0;
        mdl_reset();
        for (int i = 0; i < 3; i++) cyc(1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("restart_cnt", int'(cnt1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
